// File: rtl/vector_hazard_unit_if.sv
// ============================================================================
// Module      : vector_hazard_unit_if
// Description : Bundle of pipeline-control signals exchanged between the
//               vector CPU datapath and the hazard unit.
//               slave  : hazard unit side (consumes decode addresses and the
//                        control fields of each downstream pipeline register,
//                        produces load enables, flush, forwarding selects).
//               master : datapath side (the mirror image).
// Ports       : none (signal bundle only; clk/reset stay plain module ports)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vector_hazard_unit_if;
  // decode stage
  logic [3:0] ra1_d;
  logic [3:0] ra2_d;
  logic       use_ra1_d;
  logic       use_ra2_d;
  // execute stage
  logic [3:0] ra1_e;
  logic [3:0] ra2_e;
  logic       regwrite_e;
  logic       memtoreg_e;
  logic [3:0] wa3_e;
  // memory stage
  logic       regwrite_m;
  logic       memtoreg_m;
  logic       memwrite_m;
  logic [3:0] wa3_m;
  // writeback stage
  logic       regwrite_w;
  logic [3:0] wa3_w;
  // controls back to the pipeline registers
  logic       cargar_f;
  logic       cargar_d;
  logic       cargar_e;
  logic       cargar_m;
  logic       cargar_w;
  logic       flush_e;
  logic [1:0] fwd_a_e;
  logic [1:0] fwd_b_e;
  logic       mem_busy;

  modport slave (
    input  ra1_d, ra2_d, use_ra1_d, use_ra2_d,
    input  ra1_e, ra2_e, regwrite_e, memtoreg_e, wa3_e,
    input  regwrite_m, memtoreg_m, memwrite_m, wa3_m,
    input  regwrite_w, wa3_w,
    output cargar_f, cargar_d, cargar_e, cargar_m, cargar_w,
    output flush_e, fwd_a_e, fwd_b_e, mem_busy
  );

  modport master (
    output ra1_d, ra2_d, use_ra1_d, use_ra2_d,
    output ra1_e, ra2_e, regwrite_e, memtoreg_e, wa3_e,
    output regwrite_m, memtoreg_m, memwrite_m, wa3_m,
    output regwrite_w, wa3_w,
    input  cargar_f, cargar_d, cargar_e, cargar_m, cargar_w,
    input  flush_e, fwd_a_e, fwd_b_e, mem_busy
  );
endinterface : vector_hazard_unit_if

`default_nettype wire

// File: rtl/vector_hazard_unit.sv
// ============================================================================
// Module      : vector_hazard_unit
// Description : Pipeline control for the 16-lane vector CPU. Detects
//               load-use hazards between decode and execute (one bubble),
//               freezes the whole pipeline while a multi-cycle vector memory
//               access sits in the memory stage, and selects execute-stage
//               operand forwarding sources.
// Parameters  : LOAD_LAT - cycles a vector memory access occupies the memory
//                          stage (1..15).
// Ports       : clk   - clock
//               reset - synchronous, active-high reset
//               hz    - vector_hazard_unit_if.slave control bundle
//                       (decode/execute/memory/writeback fields in;
//                        cargar_*, flush_e, fwd_a_e, fwd_b_e, mem_busy out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_hazard_unit #(
  parameter int LOAD_LAT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vector_hazard_unit_if.slave   hz
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // WAIT is entered after the first busy cycle, so the counter covers the
  // remaining LOAD_LAT-1 cycles of the access.
  localparam logic [3:0] CNT_LOAD = 4'(LOAD_LAT - 1);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  logic [0:0] state;
  logic [0:0] state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  logic multi_cycle;
  logic mem_m;
  logic freeze;
  logic lu_hazard;

  // Single-cycle memory accesses never need to hold the pipeline.
  generate
    if (LOAD_LAT > 1) begin : g_multi
      assign multi_cycle = 1'b1;
    end else begin : g_single
      assign multi_cycle = 1'b0;
    end
  endgenerate

  assign mem_m  = hz.memtoreg_m | hz.memwrite_m;

  assign freeze = ((state == ST_RUN)  & mem_m & multi_cycle) |
                  ((state == ST_WAIT) & (cnt > 4'd1));

  // Register 0 is an ordinary vector register here, so no zero check.
  assign lu_hazard = hz.regwrite_e & hz.memtoreg_e &
                     ((hz.use_ra1_d & (hz.ra1_d == hz.wa3_e)) |
                      (hz.use_ra2_d & (hz.ra2_d == hz.wa3_e)));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_RUN: begin
        if (freeze) begin
          state_next = ST_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        cnt_next = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        // At cnt==1 the last access cycle is running unfrozen; the next op
        // may enter the memory stage right behind it.
        if (cnt <= 4'd1) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       rw_m,
    input logic [3:0] wa_m,
    input logic       rw_w,
    input logic [3:0] wa_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rw_m && (wa_m == ra)) begin
      sel = FWD_M;
    end else if (rw_w && (wa_w == ra)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  always_comb begin
    hz.cargar_f = 1'b1;
    hz.cargar_d = 1'b1;
    hz.cargar_e = 1'b1;
    hz.cargar_m = 1'b1;
    hz.cargar_w = 1'b1;
    hz.flush_e  = 1'b0;
    hz.mem_busy = 1'b0;
    hz.fwd_a_e  = FWD_RF;
    hz.fwd_b_e  = FWD_RF;

    if (reset) begin
      // Loads everywhere with execute cleared so the pipeline comes up empty.
      hz.flush_e = 1'b1;
    end else begin
      // Forwarding stays live during a freeze so the held execute operands
      // remain correct.
      hz.fwd_a_e = fwd_sel(hz.ra1_e, hz.regwrite_m, hz.wa3_m,
                           hz.regwrite_w, hz.wa3_w);
      hz.fwd_b_e = fwd_sel(hz.ra2_e, hz.regwrite_m, hz.wa3_m,
                           hz.regwrite_w, hz.wa3_w);
      if (freeze) begin
        hz.cargar_f = 1'b0;
        hz.cargar_d = 1'b0;
        hz.cargar_e = 1'b0;
        hz.cargar_m = 1'b0;
        hz.cargar_w = 1'b0;
        hz.mem_busy = 1'b1;
      end else if (lu_hazard) begin
        hz.cargar_f = 1'b0;
        hz.cargar_d = 1'b0;
        hz.flush_e  = 1'b1;
      end
    end
  end

endmodule : vector_hazard_unit

`default_nettype wire

// File: tb/tb_vector_hazard_unit.sv
// ============================================================================
// Module      : tb_vector_hazard_unit
// Description : Self-checking bench for vector_hazard_unit. Drives a
//               LOAD_LAT=4 instance and a LOAD_LAT=1 instance; each cycle's
//               expected output word is queued with the stimulus and
//               compared at the falling edge.
//               Output word: {cargar_f,d,e,m,w, flush_e, fwd_a_e, fwd_b_e,
//               mem_busy}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_hazard_unit;

  logic clk;
  logic reset;

  vector_hazard_unit_if hz4 ();
  vector_hazard_unit_if hz1 ();

  vector_hazard_unit #(.LOAD_LAT(4)) dut4 (.clk(clk), .reset(reset), .hz(hz4));
  vector_hazard_unit #(.LOAD_LAT(1)) dut1 (.clk(clk), .reset(reset), .hz(hz1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [10:0] e4;
    logic [10:0] e1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  wire logic [10:0] obs4 = {hz4.cargar_f, hz4.cargar_d, hz4.cargar_e, hz4.cargar_m,
                            hz4.cargar_w, hz4.flush_e, hz4.fwd_a_e, hz4.fwd_b_e,
                            hz4.mem_busy};
  wire logic [10:0] obs1 = {hz1.cargar_f, hz1.cargar_d, hz1.cargar_e, hz1.cargar_m,
                            hz1.cargar_w, hz1.flush_e, hz1.fwd_a_e, hz1.fwd_b_e,
                            hz1.mem_busy};

  function automatic logic [10:0] mk(input logic [4:0] en, input logic fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic busy);
    return {en, fl, fa, fb, busy};
  endfunction

  localparam logic [10:0] ALL_ON = 11'b11111_0_00_00_0;
  localparam logic [10:0] RST_O  = 11'b11111_1_00_00_0;
  localparam logic [10:0] FRZ    = 11'b00000_0_00_00_1;
  localparam logic [10:0] STALL  = 11'b00111_1_00_00_0;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock: queue expectations with the stimulus already applied, compare
  // at the falling edge, then step past the next rising edge.
  task automatic run_cycle(input string tag, input logic [10:0] e4, input logic [10:0] e1);
    exp_t item;
    exp_t got_item;
    item.tag = tag;
    item.e4  = e4;
    item.e1  = e1;
    exp_q.push_back(item);
    @(negedge clk);
    got_item = exp_q.pop_front();
    check({got_item.tag, "/L4"}, obs4, got_item.e4);
    check({got_item.tag, "/L1"}, obs1, got_item.e1);
    @(posedge clk);
    #1;
  endtask

  // The LOAD_LAT=1 instance idles unless a phase drives it explicitly.
  task automatic cyc(input string tag, input logic [10:0] e4);
    run_cycle(tag, e4, reset ? RST_O : ALL_ON);
  endtask

  task automatic idle4();
    hz4.ra1_d = 4'd0; hz4.ra2_d = 4'd0; hz4.use_ra1_d = 1'b0; hz4.use_ra2_d = 1'b0;
    hz4.ra1_e = 4'd0; hz4.ra2_e = 4'd0; hz4.regwrite_e = 1'b0; hz4.memtoreg_e = 1'b0;
    hz4.wa3_e = 4'd0; hz4.regwrite_m = 1'b0; hz4.memtoreg_m = 1'b0;
    hz4.memwrite_m = 1'b0; hz4.wa3_m = 4'd0; hz4.regwrite_w = 1'b0; hz4.wa3_w = 4'd0;
  endtask

  task automatic idle1();
    hz1.ra1_d = 4'd0; hz1.ra2_d = 4'd0; hz1.use_ra1_d = 1'b0; hz1.use_ra2_d = 1'b0;
    hz1.ra1_e = 4'd0; hz1.ra2_e = 4'd0; hz1.regwrite_e = 1'b0; hz1.memtoreg_e = 1'b0;
    hz1.wa3_e = 4'd0; hz1.regwrite_m = 1'b0; hz1.memtoreg_m = 1'b0;
    hz1.memwrite_m = 1'b0; hz1.wa3_m = 4'd0; hz1.regwrite_w = 1'b0; hz1.wa3_w = 4'd0;
  endtask

  // Load-use hazard on ra2: load in execute writing v7, decode reads v7.
  task automatic set_lu4(input logic use2);
    hz4.regwrite_e = 1'b1; hz4.memtoreg_e = 1'b1; hz4.wa3_e = 4'd7;
    hz4.ra2_d = 4'd7; hz4.use_ra2_d = use2;
  endtask

  initial begin
    reset = 1'b1;
    idle4();
    idle1();
    #1;

    // ---- reset: outputs forced even with forwarding/memory conditions live
    hz4.regwrite_m = 1'b1; hz4.wa3_m = 4'd5; hz4.ra1_e = 4'd5; hz4.memtoreg_m = 1'b1;
    cyc("reset_forced", RST_O);
    reset = 1'b0;
    idle4();
    cyc("after_reset_idle", ALL_ON);

    // ---- forwarding
    hz4.regwrite_m = 1'b1; hz4.wa3_m = 4'd5; hz4.regwrite_w = 1'b1; hz4.wa3_w = 4'd5;
    hz4.ra1_e = 4'd5; hz4.ra2_e = 4'd3;
    cyc("fwd_m_wins", mk(5'b11111, 1'b0, 2'b10, 2'b00, 1'b0));
    hz4.regwrite_m = 1'b0;
    cyc("fwd_w", mk(5'b11111, 1'b0, 2'b01, 2'b00, 1'b0));
    hz4.regwrite_m = 1'b1; hz4.wa3_m = 4'd3;
    cyc("fwd_split", mk(5'b11111, 1'b0, 2'b01, 2'b10, 1'b0));
    hz4.regwrite_w = 1'b0;
    cyc("fwd_w_disabled", mk(5'b11111, 1'b0, 2'b00, 2'b10, 1'b0));
    idle4();

    // ---- load-use
    set_lu4(1'b1);
    cyc("lu_stall", STALL);
    idle4();                      // bubble now in execute
    cyc("lu_resolved", ALL_ON);
    set_lu4(1'b0);
    cyc("lu_unused_operand", ALL_ON);
    idle4();
    hz4.regwrite_e = 1'b1; hz4.memtoreg_e = 1'b1; hz4.wa3_e = 4'd0;
    hz4.ra1_d = 4'd0; hz4.use_ra1_d = 1'b1;
    cyc("lu_ra1_reg0", STALL);
    hz4.memtoreg_e = 1'b0;
    cyc("alu_producer_no_stall", ALL_ON);
    idle4();

    // ---- single load, LOAD_LAT=4, forwarding held through the freeze
    hz4.memtoreg_m = 1'b1; hz4.regwrite_m = 1'b1; hz4.wa3_m = 4'd2; hz4.ra1_e = 4'd2;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("load_busy%0d", i), mk(5'b00000, 1'b0, 2'b10, 2'b00, 1'b1));
    cyc("load_last", mk(5'b11111, 1'b0, 2'b10, 2'b00, 1'b0));
    idle4();
    cyc("load_back_run", ALL_ON);

    // ---- two back-to-back stores
    hz4.memwrite_m = 1'b1;
    for (int i = 0; i < 8; i++)
      cyc($sformatf("store_pair%0d", i), (i % 4 == 3) ? ALL_ON : FRZ);
    idle4();
    cyc("store_pair_done", ALL_ON);

    // ---- load-use held off during freeze, one bubble after release
    hz4.memtoreg_m = 1'b1;
    set_lu4(1'b1);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("lu_frozen%0d", i), FRZ);
    cyc("lu_after_release", STALL);
    idle4();
    cyc("lu_frozen_resolved", ALL_ON);

    // ---- reset in WAIT with cnt=2
    hz4.memtoreg_m = 1'b1;
    cyc("wait_rst_c0", FRZ);          // RUN -> WAIT, cnt=3
    cyc("wait_rst_c1", FRZ);          // cnt=3 -> 2
    reset = 1'b1;
    cyc("wait_rst_forced", RST_O);    // cnt=2, reset wins
    reset = 1'b0;
    idle4();
    cyc("wait_rst_run", ALL_ON);      // back in RUN, no memory op
    hz4.memtoreg_m = 1'b1;
    cyc("wait_rst_new_op", FRZ);      // RUN path freezes again with cnt=0 start
    cyc("wait_rst_new_op1", FRZ);
    cyc("wait_rst_new_op2", FRZ);
    cyc("wait_rst_new_op3", ALL_ON);
    idle4();

    // ---- LOAD_LAT=1 instance: memory ops never freeze, hazards still work
    hz1.memtoreg_m = 1'b1; hz1.regwrite_m = 1'b1; hz1.wa3_m = 4'd9; hz1.ra2_e = 4'd9;
    for (int i = 0; i < 3; i++)
      run_cycle($sformatf("lat1_load%0d", i), ALL_ON,
                mk(5'b11111, 1'b0, 2'b00, 2'b10, 1'b0));
    hz1.memtoreg_m = 1'b0; hz1.memwrite_m = 1'b1;
    run_cycle("lat1_store", ALL_ON, mk(5'b11111, 1'b0, 2'b00, 2'b10, 1'b0));
    hz1.regwrite_e = 1'b1; hz1.memtoreg_e = 1'b1; hz1.wa3_e = 4'd4;
    hz1.ra1_d = 4'd4; hz1.use_ra1_d = 1'b1;
    run_cycle("lat1_lu", ALL_ON, mk(5'b00111, 1'b1, 2'b00, 2'b10, 1'b0));
    idle1();
    run_cycle("lat1_idle", ALL_ON, ALL_ON);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vector_hazard_unit

`default_nettype wire
